// File: rtl/conv_tap_sequencer.sv
// rtl/conv_tap_sequencer.sv - serialises one KxK window/weight set into the float MAC kernel and returns its sum
// Optional bias tap enabled by defining CONV_BIAS_EN.
module conv_tap_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int MAC_LATENCY = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] i_window,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] i_weights,
`ifdef CONV_BIAS_EN
    input  logic [DATA_WIDTH-1:0]                     i_bias,
`endif
    output logic [DATA_WIDTH-1:0]                     o_pixel,
    output logic [DATA_WIDTH-1:0]                     o_weight,
    output logic                                      o_clear,
    input  logic [DATA_WIDTH-1:0]                     i_sum,
    output logic                                      o_result_valid,
    input  logic                                      i_result_ready,
    output logic [DATA_WIDTH-1:0]                     o_result
);

    localparam int NTAP = KERNEL_SIZE * KERNEL_SIZE;
`ifdef CONV_BIAS_EN
    localparam int NFEED = NTAP + 1;
`else
    localparam int NFEED = NTAP;
`endif
    localparam int CW = $clog2(NTAP + 1);
    localparam logic [CW-1:0] LAST_TAP   = CW'(NFEED - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(MAC_LATENCY - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         tap;
    logic [CW-1:0]         drain;
    logic [DATA_WIDTH-1:0] win_buf [NFEED];
    logic [DATA_WIDTH-1:0] wgt_buf [NFEED];

    logic accept;
    assign accept = (state == IDLE) && i_valid && o_ready;

    // Window buffers carry no reset: their contents only matter after a fresh accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NTAP; i++) begin
                win_buf[i] <= i_window[i*DATA_WIDTH +: DATA_WIDTH];
                wgt_buf[i] <= i_weights[i*DATA_WIDTH +: DATA_WIDTH];
            end
`ifdef CONV_BIAS_EN
            win_buf[NTAP] <= i_bias;
            wgt_buf[NTAP] <= DATA_WIDTH'(32'h3F800000);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            o_ready        <= 1'b0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            tap            <= '0;
            drain          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= CLEAR;
                        o_ready <= 1'b0;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                    tap   <= '0;
                end
                FEED: begin
                    if (tap == LAST_TAP) begin
                        state <= DRAIN;
                        drain <= '0;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                DRAIN: begin
                    // Kernel output is complete MAC_LATENCY edges after the last tap.
                    if (drain == DRAIN_LAST) begin
                        o_result       <= i_sum;
                        o_result_valid <= 1'b1;
                        state          <= OUT;
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                OUT: begin
                    if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        o_ready        <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    // The kernel re-adds its product every cycle, so data must be zero outside FEED.
    always_comb begin
        o_pixel  = '0;
        o_weight = '0;
        o_clear  = 1'b1;
        if (state == FEED) begin
            o_pixel  = win_buf[tap];
            o_weight = wgt_buf[tap];
            o_clear  = 1'b0;
        end else if (state == DRAIN) begin
            o_clear = 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// tb/tb_conv_tap_sequencer.sv - self-checking bench for conv_tap_sequencer with a behavioural float kernel
module tb_conv_tap_sequencer;
    localparam int DW   = 32;
    localparam int K    = 3;
    localparam int NTAP = K * K;
    localparam int LAT  = 3;
`ifdef CONV_BIAS_EN
    localparam int NF = NTAP + 1;
    localparam logic [31:0] BASIC_EXP = 32'h41940000;
`else
    localparam int NF = NTAP;
    localparam logic [31:0] BASIC_EXP = 32'h41900000;
`endif
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] HALF = 32'h3F000000;

    logic clk = 1'b0;
    logic rst, i_valid, o_ready, o_clear, o_result_valid, i_result_ready;
    logic [NTAP*DW-1:0] i_window, i_weights;
    logic [DW-1:0] o_pixel, o_weight, i_sum, o_result;
    logic [DW-1:0] bias;

    always #5 clk = ~clk;

    conv_tap_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAC_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_window(i_window), .i_weights(i_weights),
`ifdef CONV_BIAS_EN
        .i_bias(bias),
`endif
        .o_pixel(o_pixel), .o_weight(o_weight), .o_clear(o_clear), .i_sum(i_sum),
        .o_result_valid(o_result_valid), .i_result_ready(i_result_ready), .o_result(o_result)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic real b2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2b(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural kernel: clearable accumulator followed by one output register.
    real acc = 0.0;
    logic [31:0] sum_d = 32'd0;
    always @(posedge clk) begin
        acc   <= o_clear ? 0.0 : acc + b2r(o_pixel) * b2r(o_weight);
        sum_d <= r2b(acc);
    end
    assign i_sum = sum_d;

    // Timeline model: phase counts cycles since the accepting edge.
    int ph = -1;
    bit after_rst = 1'b1;
    bit chk_en = 1'b0;
    int n_acc = 0;
    logic [31:0] ex_pix [NF];
    logic [31:0] ex_wgt [NF];
    logic [31:0] exp_res;
    logic [31:0] res_q [$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (ph < 0) begin
                chk("idle_ready", 32'(o_ready), 32'(!after_rst));
                chk("idle_clear", 32'(o_clear), 32'd1);
                chk("idle_pix", o_pixel, 32'd0);
                chk("idle_wgt", o_weight, 32'd0);
                chk("idle_valid", 32'(o_result_valid), 32'd0);
            end else begin
                chk("busy_ready", 32'(o_ready), 32'd0);
                if (ph == 1 || ph > NF + LAT + 1) begin
                    chk("clr_clear", 32'(o_clear), 32'd1);
                    chk("clr_pix", o_pixel, 32'd0);
                    chk("clr_wgt", o_weight, 32'd0);
                end
                if (ph <= NF + LAT + 1) chk("pre_valid", 32'(o_result_valid), 32'd0);
                if (ph >= 2 && ph <= NF + 1) begin
                    chk("feed_clear", 32'(o_clear), 32'd0);
                    chk("feed_pix", o_pixel, ex_pix[ph-2]);
                    chk("feed_wgt", o_weight, ex_wgt[ph-2]);
                end else if (ph > NF + 1 && ph <= NF + LAT + 1) begin
                    chk("drain_clear", 32'(o_clear), 32'd0);
                    chk("drain_pix", o_pixel, 32'd0);
                    chk("drain_wgt", o_weight, 32'd0);
                end else if (ph > NF + LAT + 1) begin
                    chk("out_valid", 32'(o_result_valid), 32'd1);
                    chk("out_result", o_result, exp_res);
                end
            end
            if (rst) begin
                ph = -1;
                after_rst = 1'b1;
            end else if (ph < 0) begin
                after_rst = 1'b0;
                if (o_ready && i_valid) begin
                    real s;
                    s = 0.0;
                    for (int i = 0; i < NTAP; i++) begin
                        ex_pix[i] = i_window[i*DW +: DW];
                        ex_wgt[i] = i_weights[i*DW +: DW];
                    end
`ifdef CONV_BIAS_EN
                    ex_pix[NTAP] = bias;
                    ex_wgt[NTAP] = ONE;
`endif
                    for (int i = 0; i < NF; i++) s = s + b2r(ex_pix[i]) * b2r(ex_wgt[i]);
                    exp_res = r2b(s);
                    ph = 1;
                    n_acc++;
                end
            end else if (ph > NF + LAT + 1 && i_result_ready) begin
                res_q.push_back(o_result);
                ph = -1;
            end else begin
                ph++;
            end
        end
    end

    task automatic fill(input logic [31:0] pix, input logic [31:0] wgt);
        for (int i = 0; i < NTAP; i++) begin
            i_window[i*DW +: DW]  = pix;
            i_weights[i*DW +: DW] = wgt;
        end
    endtask

    task automatic wait_accept(input int start);
        int n;
        n = 0;
        while (n_acc == start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n_acc == start) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send();
        int start;
        start = n_acc;
        i_valid = 1'b1;
        wait_accept(start);
        i_valid = 1'b0;
    endtask

    task automatic wait_res(input int idx, input string nm, input logic [31:0] exp);
        int n;
        n = 0;
        while (res_q.size() <= idx && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (res_q.size() <= idx) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else chk(nm, res_q[idx], exp);
    endtask

    initial begin
        int start;
        int n;
        rst = 1'b1; i_valid = 1'b0; i_result_ready = 1'b1; bias = '0;
        i_window = '0; i_weights = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_clear", 32'(o_clear), 32'd1);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_result", o_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fill(ONE, TWO);
        bias = HALF;
        send();
        wait_res(0, "basic", BASIC_EXP);
        bias = '0;

        for (int i = 0; i < NTAP; i++) begin
            i_window[i*DW +: DW]  = r2b(real'(i + 1));
            i_weights[i*DW +: DW] = (i == 4) ? ONE : 32'd0;
        end
        send();
        wait_res(1, "identity", 32'h40A00000);

        fill(ONE, TWO);
        start = n_acc;
        i_valid = 1'b1;
        wait_accept(start);
        fill(ONE, ONE);
        wait_accept(start + 1);
        i_valid = 1'b0;
        wait_res(2, "b2b_first", 32'h41900000);
        wait_res(3, "b2b_second", 32'h41100000);

        i_result_ready = 1'b0;
        fill(ONE, TWO);
        send();
        n = 0;
        while (!o_result_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", 32'(o_result_valid), 32'd1);
        fill(ONE, ONE);
        start = n_acc;
        i_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_result_held", o_result, 32'h41900000);
        chk("bp_no_accept", 32'(n_acc - start), 32'd0);
        i_valid = 1'b0;
        i_result_ready = 1'b1;
        wait_res(4, "bp_result", 32'h41900000);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_single_result", 32'(res_q.size()), 32'd5);
        chk("bp_idle_ready", 32'(o_ready), 32'd1);

        fill(ONE, TWO);
        send();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_clear", 32'(o_clear), 32'd1);
        chk("mid_rst_pix", o_pixel, 32'd0);
        chk("mid_rst_valid", 32'(o_result_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        send();
        wait_res(5, "after_rst", 32'h41900000);
        chk("after_rst_count", 32'(res_q.size()), 32'd6);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
